// File: rtl/binary_arith_pkg.sv
// Shared definitions for the serial add/sub sequencer: FSM encodings, mode codes
// and default geometry.
package binary_arith_pkg;

  localparam int DEF_SLICE_W = 4;
  localparam int DEF_WORDS   = 4;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_slice.sv
// Combinational SLICE_W-bit adder slice. Subtraction is handled by the caller
// pre-inverting b and driving cin=1.
module addsub_slice #(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout,
  output logic               c_msb
);

  logic [SLICE_W:0] full;

  assign full  = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
  assign sum   = full[SLICE_W-1:0];
  assign cout  = full[SLICE_W];
  // Carry into the top bit recovered from that bit's sum: s = a ^ b ^ cin.
  assign c_msb = full[SLICE_W-1] ^ a[SLICE_W-1] ^ b[SLICE_W-1];

endmodule

// File: rtl/binary_addsub_sequencer.sv
// N-bit add/subtract built by running one shared SLICE_W-bit slice WORDS times,
// LSB slice first, with valid/ready handshakes on request and result.
module binary_addsub_sequencer
  import binary_arith_pkg::*;
#(
  parameter int SLICE_W = DEF_SLICE_W,
  parameter int WORDS   = DEF_WORDS,
  localparam int N      = SLICE_W * WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         mode,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Result,
  output logic         Carry,
  output logic         Overflow,
  output state_t       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; in_ready is high only in IDLE, out_valid only in DONE, and neither
  // depends combinationally on the opposite side's valid/ready.

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_t state, state_nxt;

  logic [N-1:0]       a_q, b_q, work_q;
  logic [IW-1:0]      idx_q;
  logic               cy_q, ov_q, fin_q;
  logic               load, step, commit;
  logic [SLICE_W-1:0] sl_a, sl_b, sl_sum;
  logic               sl_cout, sl_cmsb;

  assign sl_a      = a_q[idx_q*SLICE_W +: SLICE_W];
  assign sl_b      = b_q[idx_q*SLICE_W +: SLICE_W];
  assign dbg_state = state;

  addsub_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a     (sl_a),
    .b     (sl_b),
    .cin   (cy_q),
    .sum   (sl_sum),
    .cout  (sl_cout),
    .c_msb (sl_cmsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        // The extra RUN cycle after the last slice publishes the finished word
        // so Result never shows a partially built value.
        if (fin_q) begin
          commit    = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          step = 1'b1;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      idx_q    <= '0;
      cy_q     <= 1'b0;
      ov_q     <= 1'b0;
      fin_q    <= 1'b0;
      Result   <= '0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      if (load) begin
        a_q   <= A;
        b_q   <= (mode == MODE_SUB) ? ~B : B;
        cy_q  <= mode;
        idx_q <= '0;
        fin_q <= 1'b0;
      end
      if (step) begin
        work_q[idx_q*SLICE_W +: SLICE_W] <= sl_sum;
        cy_q <= sl_cout;
        if (idx_q == LAST_IDX) begin
          fin_q <= 1'b1;
          ov_q  <= sl_cmsb ^ sl_cout;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
      if (commit) begin
        Result   <= work_q;
        Carry    <= cy_q;
        Overflow <= ov_q;
        fin_q    <= 1'b0;
      end
    end
  end

endmodule
